// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types for the two-master AXI arbiter.
//   state_e : arbiter tenure state (IDLE / RD / WR)
//   owner_t : master index (0 = IFU, 1 = LSU)
//   kind_e  : kind of transaction selected in IDLE
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  typedef logic owner_t;

  typedef enum logic {
    K_RD = 1'b0,
    K_WR = 1'b1
  } kind_e;

endpackage

// File: rtl/ysyx_24080006_axi.sv
// ysyx_24080006_axi: AXI4 bundle (32-bit address/data, 4-bit id).
//   modport master : drives aw/w/ar payload+valid, bready, rready
//   modport slave  : drives awready/wready/arready and b/r response
interface ysyx_24080006_axi;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rresp, rdata, rlast, rid,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rresp, rdata, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/axi_arb_pick.sv
// axi_arb_pick: combinational winner/kind selection for axi_arbiter.
//   rd_req/wr_req : per-master arvalid/awvalid
//   rr_ptr        : master preferred on contention (round-robin build)
//   any           : at least one master requests
//   winner        : selected master
//   kind          : K_RD if the winner has a read pending, else K_WR
// Build option: ARB_ROUND_ROBIN_EN defined -> round-robin on rr_ptr,
// otherwise fixed priority with HI_PRIO winning contention.
module axi_arb_pick
  import axi_arb_pkg::*;
#(
  parameter int HI_PRIO = 1
) (
  input  logic [1:0] rd_req,
  input  logic [1:0] wr_req,
  input  owner_t     rr_ptr,
  output logic       any,
  output owner_t     winner,
  output kind_e      kind
);

  logic [1:0] req;
  owner_t     pref;

  assign req = rd_req | wr_req;

`ifdef ARB_ROUND_ROBIN_EN
  assign pref = rr_ptr;
`else
  // Pointer still exists in the top but has no say in fixed priority.
  logic unused_ptr;
  assign unused_ptr = rr_ptr;
  assign pref       = (HI_PRIO != 0);
`endif

  always_comb begin
    any    = |req;
    winner = pref;
    if (!req[pref]) winner = ~pref;
    // Read beats write inside one master.
    kind   = rd_req[winner] ? K_RD : K_WR;
  end

endmodule

// File: rtl/axi_arbiter.sv
// axi_arbiter: two-master (m0 = IFU, m1 = LSU) to one-slave AXI arbiter.
// One whole read or write transaction is granted at a time; the grant is
// held until the final r (rlast) or b handshake, with one IDLE bubble
// between tenures. Address/data paths are combinational after the grant.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   m0,m1 : AXI slave-side ports toward the masters
//   s     : AXI master-side port toward the memory slave
// Build option: ARB_ROUND_ROBIN_EN (see axi_arb_pick) selects round-robin
// instead of fixed priority (HI_PRIO).
module axi_arbiter
  import axi_arb_pkg::*;
#(
  parameter int HI_PRIO = 1
) (
  input logic             clock,
  input logic             reset,
  ysyx_24080006_axi.slave  m0,
  ysyx_24080006_axi.slave  m1,
  ysyx_24080006_axi.master s
);

  state_e state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t rr_q, rr_d;
  logic   a_done_q, a_done_d;
  logic   w_done_q, w_done_d;

  logic [1:0] rd_req, wr_req;
  logic       pick_any;
  owner_t     pick_win;
  kind_e      pick_kind;

  logic rd_act, wr_act, sel1;
  logic ar_hs, aw_hs, w_hs, r_end, b_end;

  assign rd_req = {m1.arvalid, m0.arvalid};
  assign wr_req = {m1.awvalid, m0.awvalid};

  axi_arb_pick #(.HI_PRIO(HI_PRIO)) u_pick (
    .rd_req (rd_req),
    .wr_req (wr_req),
    .rr_ptr (rr_q),
    .any    (pick_any),
    .winner (pick_win),
    .kind   (pick_kind)
  );

  assign rd_act = (state_q == RD);
  assign wr_act = (state_q == WR);
  assign sel1   = (owner_q == 1'b1);

  // ---------------- AR: owner -> slave, dropped once accepted
  assign s.arvalid = rd_act & ~a_done_q & (sel1 ? m1.arvalid : m0.arvalid);
  assign s.araddr  = rd_act ? (sel1 ? m1.araddr  : m0.araddr)  : '0;
  assign s.arid    = rd_act ? (sel1 ? m1.arid    : m0.arid)    : '0;
  assign s.arlen   = rd_act ? (sel1 ? m1.arlen   : m0.arlen)   : '0;
  assign s.arsize  = rd_act ? (sel1 ? m1.arsize  : m0.arsize)  : '0;
  assign s.arburst = rd_act ? (sel1 ? m1.arburst : m0.arburst) : '0;
  assign m0.arready = rd_act & ~sel1 & ~a_done_q & s.arready;
  assign m1.arready = rd_act &  sel1 & ~a_done_q & s.arready;

  // ---------------- R: payload broadcast, only valid is steered
  assign s.rready  = rd_act & (sel1 ? m1.rready : m0.rready);
  assign m0.rvalid = rd_act & ~sel1 & s.rvalid;
  assign m1.rvalid = rd_act &  sel1 & s.rvalid;
  assign m0.rdata  = s.rdata;
  assign m0.rresp  = s.rresp;
  assign m0.rlast  = s.rlast;
  assign m0.rid    = s.rid;
  assign m1.rdata  = s.rdata;
  assign m1.rresp  = s.rresp;
  assign m1.rlast  = s.rlast;
  assign m1.rid    = s.rid;

  // ---------------- AW: a_done doubles as the aw-accepted flag in WR
  assign s.awvalid = wr_act & ~a_done_q & (sel1 ? m1.awvalid : m0.awvalid);
  assign s.awaddr  = wr_act ? (sel1 ? m1.awaddr  : m0.awaddr)  : '0;
  assign s.awid    = wr_act ? (sel1 ? m1.awid    : m0.awid)    : '0;
  assign s.awlen   = wr_act ? (sel1 ? m1.awlen   : m0.awlen)   : '0;
  assign s.awsize  = wr_act ? (sel1 ? m1.awsize  : m0.awsize)  : '0;
  assign s.awburst = wr_act ? (sel1 ? m1.awburst : m0.awburst) : '0;
  assign m0.awready = wr_act & ~sel1 & ~a_done_q & s.awready;
  assign m1.awready = wr_act &  sel1 & ~a_done_q & s.awready;

  // ---------------- W: independent of aw, closed by the wlast beat
  assign s.wvalid = wr_act & ~w_done_q & (sel1 ? m1.wvalid : m0.wvalid);
  assign s.wdata  = wr_act ? (sel1 ? m1.wdata : m0.wdata) : '0;
  assign s.wstrb  = wr_act ? (sel1 ? m1.wstrb : m0.wstrb) : '0;
  assign s.wlast  = wr_act ? (sel1 ? m1.wlast : m0.wlast) : 1'b0;
  assign m0.wready = wr_act & ~sel1 & ~w_done_q & s.wready;
  assign m1.wready = wr_act &  sel1 & ~w_done_q & s.wready;

  // ---------------- B
  assign s.bready  = wr_act & (sel1 ? m1.bready : m0.bready);
  assign m0.bvalid = wr_act & ~sel1 & s.bvalid;
  assign m1.bvalid = wr_act &  sel1 & s.bvalid;
  assign m0.bresp  = s.bresp;
  assign m0.bid    = s.bid;
  assign m1.bresp  = s.bresp;
  assign m1.bid    = s.bid;

  assign ar_hs = s.arvalid & s.arready;
  assign aw_hs = s.awvalid & s.awready;
  assign w_hs  = s.wvalid & s.wready & s.wlast;
  assign r_end = s.rvalid & s.rready & s.rlast;
  assign b_end = s.bvalid & s.bready;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    a_done_d = a_done_q;
    w_done_d = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d  = (pick_kind == K_RD) ? RD : WR;
          owner_d  = pick_win;
          // Next contention favours the master not granted this time.
          rr_d     = ~pick_win;
          a_done_d = 1'b0;
          w_done_d = 1'b0;
        end
      end
      RD: begin
        if (ar_hs) a_done_d = 1'b1;
        if (r_end) state_d = IDLE;
      end
      WR: begin
        if (aw_hs) a_done_d = 1'b1;
        if (w_hs)  w_done_d = 1'b1;
        if (b_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      a_done_q <= 1'b0;
      w_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      a_done_q <= a_done_d;
      w_done_q <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// tb_axi_arbiter: directed self-checking bench for axi_arbiter.
// Inputs are changed and outputs sampled at the falling clock edge.
module tb_axi_arbiter;
  import axi_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_24080006_axi m0_if ();
  ysyx_24080006_axi m1_if ();
  ysyx_24080006_axi s_if ();

  axi_arbiter #(.HI_PRIO(1)) dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic init_bus();
    m0_if.awvalid = 0; m0_if.awaddr = 0; m0_if.awid = 0; m0_if.awlen = 0; m0_if.awsize = 3'd2; m0_if.awburst = 2'd1;
    m0_if.wvalid = 0; m0_if.wdata = 0; m0_if.wstrb = 0; m0_if.wlast = 0; m0_if.bready = 0;
    m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.arid = 0; m0_if.arlen = 0; m0_if.arsize = 3'd2; m0_if.arburst = 2'd1;
    m0_if.rready = 0;
    m1_if.awvalid = 0; m1_if.awaddr = 0; m1_if.awid = 4'd1; m1_if.awlen = 0; m1_if.awsize = 3'd2; m1_if.awburst = 2'd1;
    m1_if.wvalid = 0; m1_if.wdata = 0; m1_if.wstrb = 0; m1_if.wlast = 0; m1_if.bready = 0;
    m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.arid = 4'd1; m1_if.arlen = 0; m1_if.arsize = 3'd2; m1_if.arburst = 2'd1;
    m1_if.rready = 0;
    s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = 0; s_if.bid = 0;
    s_if.arready = 0; s_if.rvalid = 0; s_if.rresp = 0; s_if.rdata = 0; s_if.rlast = 0; s_if.rid = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    init_bus();
    m0_if.arvalid = 1'b1;  // a request during reset must not be granted
    cyc(); cyc();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (dut.owner_q !== 1'b0) begin errors++; $display("FAIL rst_owner: got %0b want 0", dut.owner_q); end
    checks++; if (s_if.arvalid !== 1'b0) begin errors++; $display("FAIL rst_s_arvalid: got %0b want 0", s_if.arvalid); end
    checks++; if ({s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready} !== 4'b0) begin errors++; $display("FAIL rst_s_valids: got %b want 0000", {s_if.awvalid, s_if.wvalid, s_if.rready, s_if.bready}); end
    checks++; if (s_if.araddr !== 32'h0) begin errors++; $display("FAIL rst_s_araddr: got %h want 0", s_if.araddr); end
    checks++; if ({m0_if.arready, m1_if.arready, m0_if.awready, m1_if.wready} !== 4'b0) begin errors++; $display("FAIL rst_m_readies: got %b want 0000", {m0_if.arready, m1_if.arready, m0_if.awready, m1_if.wready}); end
    m0_if.arvalid = 1'b0;
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_m0_read();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0000; m0_if.rready = 1'b1; m1_if.rready = 1'b1;
    #1;
    checks++; if (s_if.arvalid !== 1'b0) begin errors++; $display("FAIL rd_req_cycle_arvalid: got %0b want 0", s_if.arvalid); end
    cyc();  // granted
    checks++; if (s_if.arvalid !== 1'b1) begin errors++; $display("FAIL rd_grant_arvalid: got %0b want 1", s_if.arvalid); end
    checks++; if (s_if.araddr !== 32'h8000_0000) begin errors++; $display("FAIL rd_araddr: got %h want 80000000", s_if.araddr); end
    s_if.arready = 1'b1; #1;
    checks++; if ({m0_if.arready, m1_if.arready} !== 2'b10) begin errors++; $display("FAIL rd_arready: got %b want 10", {m0_if.arready, m1_if.arready}); end
    cyc();  // ar accepted on last edge; m0 still holds arvalid here
    checks++; if (s_if.arvalid !== 1'b0) begin errors++; $display("FAIL rd_ar_after_hs: got %0b want 0", s_if.arvalid); end
    m0_if.arvalid = 1'b0; s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rdata = 32'hDEAD_BEEF; s_if.rresp = 2'd0; s_if.rlast = 1'b1; #1;
    checks++; if (m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL rd_m0_rvalid: got %0b want 1", m0_if.rvalid); end
    checks++; if (m0_if.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_m0_rdata: got %h want deadbeef", m0_if.rdata); end
    checks++; if (m0_if.rresp !== 2'd0) begin errors++; $display("FAIL rd_m0_rresp: got %0d want 0", m0_if.rresp); end
    checks++; if (m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_m1_rvalid: got %0b want 0", m1_if.rvalid); end
    checks++; if (s_if.rready !== 1'b1) begin errors++; $display("FAIL rd_s_rready: got %0b want 1", s_if.rready); end
    cyc();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rd_release_state: got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (m0_if.rvalid !== 1'b0) begin errors++; $display("FAIL rd_idle_rvalid: got %0b want 0", m0_if.rvalid); end
    s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
  endtask

  task automatic test_m1_write();
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'hA000_03F8;
    m1_if.wvalid = 1'b1; m1_if.wdata = 32'h41; m1_if.wstrb = 4'h1; m1_if.wlast = 1'b1;
    m1_if.bready = 1'b1; m0_if.bready = 1'b1;
    cyc();  // granted WR to m1
    checks++; if ({s_if.awvalid, s_if.wvalid, s_if.arvalid} !== 3'b110) begin errors++; $display("FAIL wr_valids: got %b want 110", {s_if.awvalid, s_if.wvalid, s_if.arvalid}); end
    checks++; if (s_if.awaddr !== 32'hA000_03F8) begin errors++; $display("FAIL wr_awaddr: got %h want a00003f8", s_if.awaddr); end
    checks++; if ({s_if.wdata, s_if.wstrb} !== {32'h41, 4'h1}) begin errors++; $display("FAIL wr_wdata_wstrb: got %h/%h want 41/1", s_if.wdata, s_if.wstrb); end
    s_if.awready = 1'b1; s_if.wready = 1'b1; #1;
    checks++; if ({m1_if.awready, m1_if.wready, m0_if.awready, m0_if.wready} !== 4'b1100) begin errors++; $display("FAIL wr_readies: got %b want 1100", {m1_if.awready, m1_if.wready, m0_if.awready, m0_if.wready}); end
    cyc();  // both accepted; m1 valids still high here
    checks++; if ({s_if.awvalid, s_if.wvalid} !== 2'b00) begin errors++; $display("FAIL wr_no_dup: got %b want 00", {s_if.awvalid, s_if.wvalid}); end
    m1_if.awvalid = 1'b0; m1_if.wvalid = 1'b0; s_if.awready = 1'b0; s_if.wready = 1'b0;
    s_if.bvalid = 1'b1; s_if.bresp = 2'd0; #1;
    checks++; if ({m1_if.bvalid, m0_if.bvalid} !== 2'b10) begin errors++; $display("FAIL wr_bvalid: got %b want 10", {m1_if.bvalid, m0_if.bvalid}); end
    checks++; if (s_if.bready !== 1'b1) begin errors++; $display("FAIL wr_bready: got %0b want 1", s_if.bready); end
    cyc();
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL wr_release_state: got %0d want %0d", dut.state_q, IDLE); end
    checks++; if (m1_if.bvalid !== 1'b0) begin errors++; $display("FAIL wr_idle_bvalid: got %0b want 0", m1_if.bvalid); end
    s_if.bvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_w [4];
`ifdef ARB_ROUND_ROBIN_EN
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h100;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'h200;
    for (int r = 0; r < 4; r++) begin
      cyc();  // grant cycle
      s_if.arready = 1'b1; #1;
      checks++; if ({m1_if.arready, m0_if.arready} !== (exp_w[r] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_grant%0d: got m1/m0 arready %b want winner m%0d", r, {m1_if.arready, m0_if.arready}, exp_w[r]); end
      checks++; if (s_if.araddr !== (exp_w[r] ? 32'h200 : 32'h100)) begin errors++; $display("FAIL b2b_addr%0d: got %h want %h", r, s_if.araddr, exp_w[r] ? 32'h200 : 32'h100); end
      cyc();
      s_if.arready = 1'b0;
      if (exp_w[r]) m1_if.arvalid = 1'b0; else m0_if.arvalid = 1'b0;
      s_if.rvalid = 1'b1; s_if.rlast = 1'b1; s_if.rdata = r;
      cyc();  // IDLE bubble: requests pending but nothing forwarded
      s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
      checks++; if (s_if.arvalid !== 1'b0) begin errors++; $display("FAIL b2b_bubble%0d: got %0b want 0", r, s_if.arvalid); end
      if (r < 3) begin
        if (exp_w[r]) m1_if.arvalid = 1'b1; else m0_if.arvalid = 1'b1;
      end else begin
        m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
      end
    end
    cyc();
  endtask

  task automatic test_blocked();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0010;
    cyc();  // m0 owns
    s_if.arready = 1'b1;
    m1_if.arvalid = 1'b1; m1_if.araddr = 32'hA000_0048; #1;
    checks++; if (m1_if.arready !== 1'b0) begin errors++; $display("FAIL blk_m1_arready0: got %0b want 0", m1_if.arready); end
    cyc();
    m0_if.arvalid = 1'b0; #1;
    checks++; if (m1_if.arready !== 1'b0) begin errors++; $display("FAIL blk_m1_arready1: got %0b want 0", m1_if.arready); end
    cyc();
    s_if.rvalid = 1'b1; s_if.rlast = 1'b1; s_if.rdata = 32'h1; #1;  // cycle M
    checks++; if (m1_if.arready !== 1'b0) begin errors++; $display("FAIL blk_m1_arready2: got %0b want 0", m1_if.arready); end
    checks++; if (m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL blk_m1_rvalid: got %0b want 0", m1_if.rvalid); end
    cyc();  // M+1: bubble
    s_if.rvalid = 1'b0; s_if.rlast = 1'b0; #1;
    checks++; if ({m1_if.arready, s_if.arvalid} !== 2'b00) begin errors++; $display("FAIL blk_bubble: got %b want 00", {m1_if.arready, s_if.arvalid}); end
    cyc();  // M+2: m1 granted
    checks++; if ({s_if.arvalid, m1_if.arready} !== 2'b11) begin errors++; $display("FAIL blk_m1_grant: got %b want 11", {s_if.arvalid, m1_if.arready}); end
    checks++; if (s_if.araddr !== 32'hA000_0048) begin errors++; $display("FAIL blk_m1_addr: got %h want a0000048", s_if.araddr); end
    cyc();
    m1_if.arvalid = 1'b0; s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rlast = 1'b1; #1;
    checks++; if ({m1_if.rvalid, m0_if.rvalid} !== 2'b10) begin errors++; $display("FAIL blk_m1_r: got %b want 10", {m1_if.rvalid, m0_if.rvalid}); end
    cyc();
    s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
  endtask

  task automatic test_ar_stall();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0020;
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({s_if.arvalid, m0_if.arready} !== 2'b10) begin errors++; $display("FAIL stall_wait%0d: got %b want 10", i, {s_if.arvalid, m0_if.arready}); end
      cyc();
    end
    s_if.arready = 1'b1; #1;
    checks++; if (m0_if.arready !== 1'b1) begin errors++; $display("FAIL stall_hs: got %0b want 1", m0_if.arready); end
    cyc();
    checks++; if (s_if.arvalid !== 1'b0) begin errors++; $display("FAIL stall_drop: got %0b want 0", s_if.arvalid); end
    m0_if.arvalid = 1'b0; s_if.arready = 1'b0;
    cyc();
    checks++; if (s_if.arvalid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got %0b want 0", s_if.arvalid); end
    s_if.rvalid = 1'b1; s_if.rlast = 1'b1;
    cyc();
    s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL stall_release: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_reset_mid();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0030;
    cyc();
    checks++; if (s_if.arvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %0b want 1", s_if.arvalid); end
    s_if.arready = 1'b1; s_if.rvalid = 1'b1; s_if.rlast = 1'b1;
    reset = 1'b0; #1;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_state: got %0d want %0d", dut.state_q, IDLE); end
    checks++; if ({s_if.arvalid, m0_if.arready, m0_if.rvalid, s_if.rready} !== 4'b0) begin errors++; $display("FAIL rmid_outs: got %b want 0000", {s_if.arvalid, m0_if.arready, m0_if.rvalid, s_if.rready}); end
    checks++; if (s_if.araddr !== 32'h0) begin errors++; $display("FAIL rmid_araddr: got %h want 0", s_if.araddr); end
    m0_if.arvalid = 1'b0; s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    m0_if.arvalid = 1'b1; m0_if.araddr = 32'h8000_0040;
    cyc();
    checks++; if ({s_if.arvalid, s_if.araddr} !== {1'b1, 32'h8000_0040}) begin errors++; $display("FAIL rmid_fresh_ar: got %0b/%h want 1/80000040", s_if.arvalid, s_if.araddr); end
    s_if.arready = 1'b1;
    cyc();
    m0_if.arvalid = 1'b0; s_if.arready = 1'b0;
    s_if.rvalid = 1'b1; s_if.rlast = 1'b1; s_if.rdata = 32'hCAFE_F00D; #1;
    checks++; if ({m0_if.rvalid, m0_if.rdata} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL rmid_fresh_r: got %0b/%h want 1/cafef00d", m0_if.rvalid, m0_if.rdata); end
    cyc();
    s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_fresh_release: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_m1_write();
    test_back_to_back();
    test_blocked();
    test_ar_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
